// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection traffic-light sequencer.
package intersection_pkg;

  // Phase states. The encoding is exported on state_o for debug and display.
  typedef enum logic [2:0] {
    ALL_RED_A   = 3'd0,
    MAIN_GREEN  = 3'd1,
    MAIN_YELLOW = 3'd2,
    ALL_RED_B   = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    FLASH       = 3'd6
  } state_e;

  // Lamp drives, {red, yellow, green}.
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  // Default interval durations in seconds, and the seconds-counter width.
  localparam int DEF_T_MAIN_GREEN = 20;
  localparam int DEF_T_SIDE_GREEN = 10;
  localparam int DEF_T_YELLOW     = 3;
  localparam int DEF_T_ALL_RED    = 2;
  localparam int DEF_CNT_W        = 6;

endpackage

// File: rtl/intersection_if.sv
// Signal bundle between the intersection controller and its environment.
// Contract: tick_i is a single-cycle pulse synchronous to the controller clock;
// req_side_i, req_ped_i and flash_i are pre-synchronized levels sampled on every
// edge; every output is a function of controller registers only and is valid
// on every cycle (there is no valid/ready pairing, nothing is ever back-pressured).
interface intersection_if #(
  parameter int CNT_W = 6
);
  logic             tick_i;
  logic             req_side_i;
  logic             req_ped_i;
  logic             flash_i;
  logic [2:0]       main_light_o;
  logic [2:0]       side_light_o;
  logic             walk_o;
  logic [CNT_W-1:0] sec_left_o;
  logic [2:0]       state_o;

  // Environment side: drives tick and requests, observes lamps.
  modport master (
    output tick_i, req_side_i, req_ped_i, flash_i,
    input  main_light_o, side_light_o, walk_o, sec_left_o, state_o
  );

  // Controller side.
  modport slave (
    input  tick_i, req_side_i, req_ped_i, flash_i,
    output main_light_o, side_light_o, walk_o, sec_left_o, state_o
  );
endinterface

// File: rtl/intersection_controller_interval_timer.sv
// Loadable seconds down-counter. Load wins over counting; the count never
// wraps below zero, and with hold_i set it parks at 1 instead of reaching 0.
module interval_timer #(
  parameter int               CNT_W   = 6,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] count_o,
  output logic             expire_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // Counter register: reset, load, or decrement on tick.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= RST_VAL;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != '0) && !(hold_i && (count_q == ONE))) begin
      count_q <= count_q - ONE;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == ONE);

endmodule

// File: rtl/intersection_controller.sv
// Two-road traffic-light sequencer: phase FSM, demand flags, flashing mode and
// lamp decode. Timing is in seconds counted off a 1 Hz single-cycle tick.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int T_MAIN_GREEN = DEF_T_MAIN_GREEN,
  parameter int T_SIDE_GREEN = DEF_T_SIDE_GREEN,
  parameter int T_YELLOW     = DEF_T_YELLOW,
  parameter int T_ALL_RED    = DEF_T_ALL_RED,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_ni,
  intersection_if.slave bus
);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic             ped_q, ped_d;
  logic             walk_q, walk_d;
  logic             blink_q, blink_d;
  logic             expire;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             enter_side_green;

  // Duration loaded when a state is entered; FLASH shows zero.
  function automatic logic [CNT_W-1:0] duration(input state_e s);
    case (s)
      ALL_RED_A, ALL_RED_B:     return CNT_W'(T_ALL_RED);
      MAIN_GREEN:               return CNT_W'(T_MAIN_GREEN);
      MAIN_YELLOW, SIDE_YELLOW: return CNT_W'(T_YELLOW);
      SIDE_GREEN:               return CNT_W'(T_SIDE_GREEN);
      default:                  return '0;
    endcase
  endfunction

  // Any state change reloads the timer with the new state's duration.
  assign load     = (state_d != state_q);
  assign load_val = duration(state_d);

  interval_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_ALL_RED))
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tick_i     (bus.tick_i),
    .load_i     (load),
    .load_val_i (load_val),
    .hold_i     (state_q == MAIN_GREEN),
    .count_o    (count),
    .expire_o   (expire)
  );

  // Next-state logic: flash request overrides everything, else advance on expiry.
  always_comb begin
    state_d = state_q;
    if (bus.flash_i) begin
      state_d = FLASH;
    end else begin
      case (state_q)
        ALL_RED_A:   if (expire) state_d = MAIN_GREEN;
        MAIN_GREEN:  if (expire && pending_q) state_d = MAIN_YELLOW;
        MAIN_YELLOW: if (expire) state_d = ALL_RED_B;
        ALL_RED_B:   if (expire) state_d = SIDE_GREEN;
        SIDE_GREEN:  if (expire) state_d = SIDE_YELLOW;
        SIDE_YELLOW: if (expire) state_d = ALL_RED_A;
        FLASH:       state_d = ALL_RED_A;
        default:     state_d = ALL_RED_A;
      endcase
    end
  end

  assign enter_side_green = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);

  // Flag, walk and blink updates; a new request wins over a same-edge clear.
  always_comb begin
    pending_d = (pending_q && !enter_side_green) || bus.req_side_i || bus.req_ped_i;
    ped_d     = (ped_q && !enter_side_green) || bus.req_ped_i;
    walk_d    = 1'b0;
    if (state_d == SIDE_GREEN) begin
      walk_d = enter_side_green ? ped_q : walk_q;
    end
    blink_d = 1'b0;
    if (state_d == FLASH) begin
      blink_d = (state_q == FLASH && bus.tick_i) ? !blink_q : blink_q;
    end
  end

  // State and flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ALL_RED_A;
      pending_q <= 1'b0;
      ped_q     <= 1'b0;
      walk_q    <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ped_q     <= ped_d;
      walk_q    <= walk_d;
      blink_q   <= blink_d;
    end
  end

  // Lamp decode from registered state, so lamps switch on the state-change edge.
  always_comb begin
    bus.main_light_o = LIGHT_RED;
    bus.side_light_o = LIGHT_RED;
    case (state_q)
      MAIN_GREEN:  bus.main_light_o = LIGHT_GRN;
      MAIN_YELLOW: bus.main_light_o = LIGHT_YEL;
      SIDE_GREEN:  bus.side_light_o = LIGHT_GRN;
      SIDE_YELLOW: bus.side_light_o = LIGHT_YEL;
      FLASH: begin
        bus.main_light_o = blink_q ? LIGHT_YEL : LIGHT_OFF;
        bus.side_light_o = blink_q ? LIGHT_YEL : LIGHT_OFF;
      end
      default: ;
    endcase
  end

  assign bus.walk_o     = walk_q;
  assign bus.sec_left_o = count;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench for intersection_controller with short intervals:
// main green 4, side green 3, yellow 2, all-red 1; a tick every 10 clocks.
module tb_intersection_controller;
  import intersection_pkg::*;

  localparam int CNT_W = 6;

  logic clk_i;
  logic rst_ni;
  int   checks   = 0;
  int   failures = 0;

  intersection_if #(.CNT_W(CNT_W)) bus ();

  intersection_controller #(
    .T_MAIN_GREEN (4),
    .T_SIDE_GREEN (3),
    .T_YELLOW     (2),
    .T_ALL_RED    (1),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Clock and reset.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Driver tasks: all drives and samples happen 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic tick_edge();
    bus.tick_i = 1'b1;
    @(posedge clk_i);
    #1;
    bus.tick_i = 1'b0;
  endtask

  task automatic do_tick();
    idle(9);
    tick_edge();
  endtask

  // Scoreboard comparison.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input state_e st, input logic [2:0] ml,
                            input logic [2:0] sl, input logic w, input int sec);
    chk({tag, ".state"}, 32'(bus.state_o), 32'(st));
    chk({tag, ".main"},  32'(bus.main_light_o), 32'(ml));
    chk({tag, ".side"},  32'(bus.side_light_o), 32'(sl));
    chk({tag, ".walk"},  32'(bus.walk_o), 32'(w));
    chk({tag, ".sec"},   32'(bus.sec_left_o), 32'(sec));
  endtask

  initial begin
    rst_ni         = 1'b0;
    bus.tick_i     = 1'b0;
    bus.req_side_i = 1'b0;
    bus.req_ped_i  = 1'b0;
    bus.flash_i    = 1'b0;
    idle(3);
    expect_out("reset", ALL_RED_A, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    rst_ni = 1'b1;

    // First tick expires the 1 s all-red.
    do_tick();
    expect_out("first_tick", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 4);
    do_tick();
    expect_out("mg_count", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 3);

    // No demand: main green parks at 1.
    for (int i = 0; i < 20; i++) do_tick();
    expect_out("mg_park", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 1);

    // One-cycle side request; transition waits for the next tick.
    bus.req_side_i = 1'b1;
    idle(1);
    bus.req_side_i = 1'b0;
    expect_out("side_req_notick", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("s1_my", MAIN_YELLOW, LIGHT_YEL, LIGHT_RED, 1'b0, 2);
    do_tick();
    expect_out("s1_my1", MAIN_YELLOW, LIGHT_YEL, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("s1_arb", ALL_RED_B, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("s1_sg", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b0, 3);
    do_tick();
    do_tick();
    expect_out("s1_sg1", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b0, 1);
    do_tick();
    expect_out("s1_sy", SIDE_YELLOW, LIGHT_RED, LIGHT_YEL, 1'b0, 2);
    do_tick();
    do_tick();
    expect_out("s1_ara", ALL_RED_A, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("s1_mg", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 4);
    // Pending was cleared on side-green entry: main green parks again.
    for (int i = 0; i < 5; i++) do_tick();
    expect_out("s1_pend_clr", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 1);

    // Pedestrian request held across side-green entry.
    bus.req_ped_i = 1'b1;
    idle(1);
    do_tick();
    expect_out("p_my", MAIN_YELLOW, LIGHT_YEL, LIGHT_RED, 1'b0, 2);
    do_tick();
    do_tick();
    expect_out("p_arb", ALL_RED_B, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("p_sg", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b1, 3);
    bus.req_ped_i = 1'b0;
    do_tick();
    expect_out("p_sg2", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b1, 2);
    do_tick();
    expect_out("p_sg1", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b1, 1);
    do_tick();
    expect_out("p_sy", SIDE_YELLOW, LIGHT_RED, LIGHT_YEL, 1'b0, 2);
    do_tick();
    do_tick();
    expect_out("p_ara", ALL_RED_A, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("p_mg", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 4);
    do_tick();
    do_tick();
    do_tick();
    expect_out("p_mg1", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 1);
    // Flags re-latched during the held request: a second cycle runs unprompted.
    do_tick();
    expect_out("p2_my", MAIN_YELLOW, LIGHT_YEL, LIGHT_RED, 1'b0, 2);
    do_tick();
    do_tick();
    do_tick();
    expect_out("p2_sg", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b1, 3);
    do_tick();
    do_tick();
    expect_out("p2_sg1", SIDE_GREEN, LIGHT_RED, LIGHT_GRN, 1'b1, 1);

    // Flash raised together with the side-green expiry tick.
    idle(9);
    bus.flash_i = 1'b1;
    tick_edge();
    expect_out("f_enter", FLASH, LIGHT_OFF, LIGHT_OFF, 1'b0, 0);
    do_tick();
    expect_out("f_on", FLASH, LIGHT_YEL, LIGHT_YEL, 1'b0, 0);
    do_tick();
    expect_out("f_off", FLASH, LIGHT_OFF, LIGHT_OFF, 1'b0, 0);
    do_tick();
    expect_out("f_on2", FLASH, LIGHT_YEL, LIGHT_YEL, 1'b0, 0);
    bus.flash_i = 1'b0;
    idle(1);
    expect_out("f_exit", ALL_RED_A, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    do_tick();
    expect_out("f_mg", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 4);

    // Reset in the middle of main yellow.
    do_tick();
    do_tick();
    do_tick();
    bus.req_side_i = 1'b1;
    idle(1);
    bus.req_side_i = 1'b0;
    do_tick();
    expect_out("r_my", MAIN_YELLOW, LIGHT_YEL, LIGHT_RED, 1'b0, 2);
    rst_ni = 1'b0;
    idle(1);
    expect_out("r_reset", ALL_RED_A, LIGHT_RED, LIGHT_RED, 1'b0, 1);
    rst_ni = 1'b1;
    do_tick();
    expect_out("r_mg", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 4);
    for (int i = 0; i < 4; i++) do_tick();
    expect_out("r_flags_clr", MAIN_GREEN, LIGHT_GRN, LIGHT_RED, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Traffic-light sequencer for the two-road automatic intersection. It consumes the 1 Hz tick produced by the frequency divider as a single-cycle enable in the 100 MHz domain. It runs the main/side phase state machine with yellow and all-red clearance intervals, demand-actuated side-road and pedestrian service, and a night/fault flashing-yellow mode. It exports the light drives, the walk signal, and a seconds-remaining count for the display multiplexer.

## Interface
- T_MAIN_GREEN, 20: minimum main-road green, seconds
- T_SIDE_GREEN, 10: side-road green, seconds
- T_YELLOW, 3: yellow interval, seconds
- T_ALL_RED, 2: all-red clearance, seconds
- CNT_W, 6: width of the seconds counter; every T_* must satisfy 1 ≤ T ≤ 2^CNT_W−1
- clk_i  in  1  system clock, 100 MHz
- rst_ni  in  1  reset, synchronous, active-low
- tick_i  in  1  one-cycle pulse at 1 Hz, synchronous to clk_i
- req_side_i  in  1  side-road vehicle sensor, level, pre-synchronized
- req_ped_i  in  1  pedestrian button, level, pre-synchronized
- flash_i  in  1  night/fault mode request, level
- main_light_o  out  3  {red, yellow, green}, one-hot or all-zero
- side_light_o  out  3  {red, yellow, green}, one-hot or all-zero
- walk_o  out  1  pedestrian walk lamp
- sec_left_o  out  CNT_W  seconds remaining in the current timed state
- state_o  out  3  current state encoding, for debug and display

## Operation
- States: ALL_RED_A, MAIN_GREEN, MAIN_YELLOW, ALL_RED_B, SIDE_GREEN, SIDE_YELLOW, FLASH.
- Reset values: state ALL_RED_A; sec_left_o = T_ALL_RED; main_light_o = side_light_o = 3'b100; walk_o = 0; pending and ped flags = 0; blink = 0.
- Timer behaviour:
  - On entry to a timed state, sec_left is loaded with that state's duration.
  - On each tick_i, sec_left decrements.
  - An edge with tick_i = 1 and sec_left = 1 is the expiry edge: the state changes and the next duration is loaded on that same edge.
- Transitions:
  - ALL_RED_A → MAIN_GREEN.
  - MAIN_GREEN → MAIN_YELLOW at expiry only if pending = 1. Otherwise the state holds with sec_left = 1, and the transition occurs on the first tick with pending = 1.
  - MAIN_YELLOW → ALL_RED_B → SIDE_GREEN → SIDE_YELLOW → ALL_RED_A.
- Lights:
  - MAIN_GREEN: main green, side red.
  - MAIN_YELLOW: main yellow, side red.
  - SIDE_GREEN: main red, side green.
  - SIDE_YELLOW: main red, side yellow.
  - ALL_RED_*: both red.
  - FLASH: both outputs are {0, blink, 0}.
- pending flag: set on any cycle with req_side_i or req_ped_i high. Cleared on the edge entering SIDE_GREEN. If a set and the clear happen on the same edge, set wins.
- ped flag: set by req_ped_i. On entry to SIDE_GREEN, walk_o = ped and ped clears (set wins here too). walk_o drops on leaving SIDE_GREEN.
- flash_i = 1, sampled in any state, moves the block to FLASH on the next edge. flash_i has priority over a simultaneous expiry.
  - In FLASH: blink toggles on each tick, sec_left_o = 0, walk_o = 0, flags are retained.
  - On flash_i = 0: go to ALL_RED_A with blink = 0.
- Arithmetic: sec_left never underflows. No decrement at 0 and none when holding at 1 in MAIN_GREEN.

## Timing
- All outputs are registered and reflect the state one edge after the causing input.
- Output latency: light outputs change on the same edge as the state change; zero extra cycles.
- A timed state lasts between (T−1) and T seconds of wall time, because entry is asynchronous to tick phase. After the first tick it lasts exactly T−1 further ticks.
- Reset mid-operation: any rst_ni = 0 edge forces reset values. This includes FLASH and any partial sec_left.
- tick_i high for more than one cycle is a protocol violation and is not handled.

## Structure
- Package intersection_pkg holds:
  - the state enum
  - light encodings: LIGHT_RED = 3'b100, LIGHT_YEL = 3'b010, LIGHT_GRN = 3'b001, LIGHT_OFF
  - default durations
- One sub-module, interval_timer: a loadable CNT_W down-counter with a tick enable, load value, hold input, and expiry output (expiry = tick & count == 1).
- The controller holds the FSM, request flags, blink register and output decode.
- Expected size: about 200 lines.

## Test plan
Use T_MAIN_GREEN = 4, T_SIDE_GREEN = 3, T_YELLOW = 2, T_ALL_RED = 1 and a tick every 10 clocks.

- Reset hold, then release:
  - All outputs at reset values, sec_left_o = 1.
  - After the first tick: MAIN_GREEN, main = 001, sec_left_o = 4.
- No requests for 20 ticks: stays MAIN_GREEN with sec_left_o parked at 1.
- req_side_i pulsed for 1 cycle during MAIN_GREEN:
  - Sequence MAIN_YELLOW(2) → ALL_RED_B(1) → SIDE_GREEN(3) → SIDE_YELLOW(2) → ALL_RED_A(1) → MAIN_GREEN.
  - walk_o = 0 throughout; pending = 0 after SIDE_GREEN entry.
- req_ped_i held high across the SIDE_GREEN entry edge:
  - walk_o = 1 for all of SIDE_GREEN.
  - ped re-latched, so the next cycle also serves walk.
- flash_i raised mid-SIDE_GREEN on the same cycle as an expiry tick:
  - FLASH entered; both lights alternate 010 and 000 on each tick; walk_o = 0.
  - flash_i drop → ALL_RED_A, then MAIN_GREEN.
- rst_ni asserted during MAIN_YELLOW with sec_left_o = 2: next edge shows ALL_RED_A, both 100, sec_left_o = 1, flags cleared.
